// File: rtl/fdcp_init_pkg.sv
// Shared encodings and legal parameter limits for the async clear/preset
// init sequencer and its synchronizer.
package fdcp_init_pkg;

    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_READY   = 3'd4;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int STRETCH_MIN     = 1;
    localparam int REQ_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_RESET   = ST_RESET,
        S_SYNC    = ST_SYNC,
        S_HOLD    = ST_HOLD,
        S_RELEASE = ST_RELEASE,
        S_READY   = ST_READY
    } state_t;

    // States in which the downstream clear/preset lines are driven.
    function automatic logic is_asrt_state(state_t s);
        return (s == S_RESET) || (s == S_SYNC) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/fdcp_rst_sync.sv
// Async-assert / sync-deassert shift chain. Clears to 0 on CLR_N low and
// shifts d in; q_pre is the stage feeding q, i.e. what q becomes next edge.
module fdcp_rst_sync
    import fdcp_init_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic C,
    input  logic CLR_N,
    input  logic d,
    output logic q,
    output logic q_pre
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("fdcp_rst_sync: SYNC_STAGES below legal minimum");
    end

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q     = chain[SYNC_STAGES-1];
    assign q_pre = chain[SYNC_STAGES-2];

endmodule

// File: rtl/fdcp_init_seq.sv
// Init sequencer for downstream async clear/preset flops: asserts CLR/PRE per
// INIT on reset or re-init request. Optional macro: FDCP_INIT_SEQ_REQ_SYNC_EN.
module fdcp_init_seq
    import fdcp_init_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}},
    parameter int               SYNC_STAGES = 2,
    parameter int               STRETCH     = 4
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             REQ,
    output logic             ACK,
    output logic [WIDTH-1:0] CLR,
    output logic [WIDTH-1:0] PRE,
    output logic             RDY
);

    localparam int             CW       = $clog2(STRETCH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(STRETCH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("fdcp_init_seq: SYNC_STAGES below legal minimum");
    end
    if (STRETCH < STRETCH_MIN) begin : g_bad_stretch
        $error("fdcp_init_seq: STRETCH below legal minimum");
    end

    state_t        state;
    state_t        state_nxt;
    logic          asrt;
    logic          asrt_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ack_nxt;
    logic          rdy_nxt;
    logic          req_eff;
    logic          req_hist;
    logic          req_rise;
    logic          rst_done;
    logic          rst_pre;

    // The FSM leaves SYNC on the same edge the synchronizer output rises,
    // so it watches the stage just before the output.
    fdcp_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .C     (C),
        .CLR_N (CLR_N),
        .d     (1'b1),
        .q     (rst_done),
        .q_pre (rst_pre)
    );

`ifdef FDCP_INIT_SEQ_REQ_SYNC_EN
    logic req_sync_pre;

    fdcp_rst_sync #(
        .SYNC_STAGES (REQ_SYNC_STAGES)
    ) u_req_sync (
        .C     (C),
        .CLR_N (CLR_N),
        .d     (REQ),
        .q     (req_eff),
        .q_pre (req_sync_pre)
    );
`else
    assign req_eff = REQ;
`endif

    // REQ/ACK: a REQ low->high transition seen while RDY=1 is accepted on that
    // edge; ACK is high for exactly that one cycle, RDY drops with it. REQ
    // edges outside READY are dropped, and a held REQ must be seen low first.
    assign req_rise = req_eff & ~req_hist;

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= S_RESET;
            asrt     <= 1'b1;
            cnt      <= '0;
            ACK      <= 1'b0;
            RDY      <= 1'b0;
            req_hist <= 1'b1;
        end else begin
            state    <= state_nxt;
            asrt     <= asrt_nxt;
            cnt      <= cnt_nxt;
            ACK      <= ack_nxt;
            RDY      <= rdy_nxt;
            req_hist <= req_eff;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        rdy_nxt   = 1'b0;
        case (state)
            S_RESET: begin
                state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (rst_pre) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            S_HOLD: begin
                if (cnt > CNT_ONE) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (rst_done) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                state_nxt = S_READY;
                rdy_nxt   = 1'b1;
            end
            S_READY: begin
                if (req_rise) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = CNT_LOAD;
                    ack_nxt   = 1'b1;
                end else begin
                    rdy_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_RESET;
                cnt_nxt   = '0;
            end
        endcase
        asrt_nxt = is_asrt_state(state_nxt);
    end

    // Gating a single flop with a constant mask keeps each line glitch-free.
    assign CLR = {WIDTH{asrt}} & ~INIT;
    assign PRE = {WIDTH{asrt}} &  INIT;

endmodule

// File: doc/fdcp_init_seq.md
FDCP_INIT_SEQ -- requirements
Module: fdcp_init_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of downstream async clear/preset flops driven.
REQ-002 SHALL have parameter INIT, default {WIDTH{1'b0}}: per-bit init value; bit=1 drives PRE, bit=0 drives CLR.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal >=2: reset-deassertion synchronizer depth.
REQ-004 SHALL have parameter STRETCH, default 4, legal >=1: cycles the init controls stay asserted after sync.
REQ-005 SHALL have port C  input  1: clock, all state updates on rising edge.
REQ-006 SHALL have port CLR_N  input  1: asynchronous active-low reset.
REQ-007 SHALL have port REQ  input  1: re-initialisation request, rising-edge sensitive.
REQ-008 SHALL have port ACK  output  1: one-cycle pulse acknowledging an accepted REQ.
REQ-009 SHALL have port CLR  output  WIDTH: per-bit active-high async clear to downstream flops.
REQ-010 SHALL have port PRE  output  WIDTH: per-bit active-high async preset to downstream flops.
REQ-011 SHALL have port RDY  output  1: high when init complete and idle.

Function
REQ-012 SHALL implement states RESET, SYNC, HOLD, RELEASE, READY.
REQ-013 SHALL compute CLR = {WIDTH{asrt}} & ~INIT and PRE = {WIDTH{asrt}} & INIT, asrt a registered flag; CLR and PRE never both high on one bit.
REQ-014 SHALL hold asrt=1 in RESET, SYNC, HOLD; asrt=0 in RELEASE, READY.
REQ-015 SHALL move RESET->SYNC on the first rising edge with CLR_N high; SYNC->HOLD when synchronizer output goes high (SYNC_STAGES edges after CLR_N rise).
REQ-016 SHALL count STRETCH cycles in HOLD with a counter of width $clog2(STRETCH+1), then go RELEASE; total: CLR/PRE deassert on edge SYNC_STAGES+STRETCH after CLR_N rise.
REQ-017 SHALL spend exactly one cycle in RELEASE (settle), then enter READY with RDY=1 on the following edge.
REQ-018 SHALL, in READY, on a detected REQ rising edge: pulse ACK for one cycle, drop RDY, set asrt, enter HOLD (counter reloaded) on the same edge.
REQ-019 SHALL ignore REQ edges in any state other than READY; REQ held high re-triggers only after a low sample.
REQ-020 SHALL keep ACK=0 except the single cycle of REQ-018.

Reset
REQ-021 SHALL, on CLR_N low, asynchronously force state=RESET, asrt=1 (CLR/PRE asserted per INIT immediately), RDY=0, ACK=0, counter=0, REQ edge detector history=1.
REQ-022 SHALL treat CLR_N low mid-HOLD, RELEASE or READY identically to power-on: immediate async assertion, full sequence on release.
REQ-023 SHALL deassert internal reset only through the SYNC_STAGES synchronizer; asynchronous assertion, synchronous deassertion.

Configuration
REQ-024 SHALL support macro FDCP_INIT_SEQ_REQ_SYNC_EN: when defined, REQ passes a 2-flop synchronizer before edge detection (+2 cycles REQ-to-ACK latency); when undefined, REQ is sampled directly (ACK one edge after REQ rise observed).

Structure
REQ-025 SHALL place state encodings (3-bit localparams ST_RESET..ST_READY) and legal-range limits in shared package fdcp_init_pkg.
REQ-026 SHALL instantiate one sub-module fdcp_rst_sync (async-assert/sync-deassert chain, parameter SYNC_STAGES), reused for the REQ synchronizer when FDCP_INIT_SEQ_REQ_SYNC_EN is defined.
REQ-027 SHALL register all outputs (no combinational path from REQ to outputs).

Verification
REQ-028 SHALL test power-on: WIDTH=8, INIT=8'hA5, SYNC_STAGES=2, STRETCH=4, CLR_N low -> CLR=8'h5A, PRE=8'hA5 immediately; CLR_N rises -> both 0 at edge 6, RDY=1 at edge 7.
REQ-029 SHALL test re-init: REQ 0->1 in READY (macro off) -> ACK=1 one cycle, RDY=0, CLR/PRE asserted 4 cycles, RDY back after RELEASE.
REQ-030 SHALL test REQ held high 20 cycles after ACK -> exactly one ACK; REQ pulsed during HOLD -> no ACK, timing unchanged.
REQ-031 SHALL test CLR_N pulsed low during HOLD and during READY -> CLR/PRE assert without clock edge, full 6+1 cycle sequence repeats.
REQ-032 SHALL test macro defined: REQ rise in READY -> ACK two cycles later than macro-off run; STRETCH=1 -> CLR/PRE deassert at edge 3.
